// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment encodings and FSM state codes.
// Segments are active-low {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Entry h holds the active-low pattern for hex digit h (entry 0 is the rightmost element).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef logic [0:0] state_t;

    localparam state_t ST_SHOW = 1'b0;
    localparam state_t ST_GAP  = 1'b1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with valid/ready load and frame-aligned update.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           pending_q, pending_d;
    logic                    pendingFull_q, pendingFull_d;
    logic [DW-1:0]           display_q, display_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    frameBoundary;
    logic [3:0]              curNib;
    logic [6:0]              decSeg;
    logic [NUM_DIGITS-1:0]   anSel;
    logic                    lzbDark;
    logic                    dark;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        case (state_q)
            ST_SHOW: begin
                if (pre_q == PRE_MAX) begin
                    pre_d   = '0;
                    idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                    state_d = ST_GAP;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = ST_SHOW;
        endcase
    end

    // The GAP after the last digit has already wrapped idx to 0, which marks the frame boundary.
    assign frameBoundary = (state_q == ST_GAP) && (idx_q == '0);
    assign load_ready    = ~pendingFull_q;

    always_comb begin
        pending_d     = pending_q;
        pendingFull_d = pendingFull_q;
        display_d     = display_q;
        if (frameBoundary && pendingFull_q) begin
            display_d     = pending_q;
            pendingFull_d = 1'b0;
        end else if (load_valid && load_ready) begin
            pending_d     = load_data;
            pendingFull_d = 1'b1;
        end
    end

    always_comb begin
        curNib = 4'h0;
        anSel  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                curNib   = display_q[4*k +: 4];
                anSel[k] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble_i (curNib),
        .seg_o    (decSeg)
    );

`ifdef SEG7_LZB_EN
    // A digit above 0 goes dark when it and every more significant nibble are zero.
    logic zerosAbove;
    always_comb begin
        zerosAbove = 1'b1;
        lzbDark    = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zerosAbove = zerosAbove & (display_q[4*k +: 4] == 4'h0);
            if ((k > 0) && zerosAbove && anSel[k]) begin
                lzbDark = 1'b1;
            end
        end
    end
`else
    assign lzbDark = 1'b0;
`endif

    assign dark = blank || (state_q == ST_GAP) || lzbDark;

    always_comb begin
        seg_d = decSeg;
        an_d  = ~anSel;
        if (dark) begin
            seg_d = SEG_OFF;
            an_d  = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SHOW;
            pre_q         <= '0;
            idx_q         <= '0;
            pending_q     <= '0;
            pendingFull_q <= 1'b0;
            display_q     <= '0;
            seg_q         <= SEG_OFF;
            an_q          <= '1;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            pendingFull_q <= pendingFull_d;
            display_q     <= display_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4) against a timeline model.
// Honours SEG7_LZB_EN in its model when the macro is defined for the build.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int SLOT  = R + 1;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        loadValid = 1'b0;
    logic        loadReady;
    logic [15:0] loadData = 16'h0000;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;

    int tests = 0;
    int fails = 0;

    int          mCycle;
    logic [15:0] mDisplay;
    logic [15:0] mPending;
    logic        mFull;
    logic [6:0]  expSeg;
    logic [3:0]  expAn;
    logic        ok;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (loadValid),
        .load_ready (loadReady),
        .load_data  (loadData),
        .blank      (blank),
        .seg        (seg),
        .an         (an)
    );

    function automatic logic [6:0] hexSeg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic digitLit(input int s, input logic [15:0] disp);
`ifdef SEG7_LZB_EN
        return (s == 0) || ((disp >> (4 * s)) != 16'h0000);
`else
        return (s >= 0) || (disp == disp);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, mCycle);
        end
    endtask

    task automatic modelReset();
        mCycle   = 0;
        mDisplay = 16'h0000;
        mPending = 16'h0000;
        mFull    = 1'b0;
    endtask

    // Predicts the outputs after the coming edge from the slot timeline, then checks them.
    task automatic applyStimulus();
        int   f, s, p;
        logic bnd;
        f = mCycle % FRAME;
        s = f / SLOT;
        p = f % SLOT;
        if (blank || (p == R) || !digitLit(s, mDisplay)) begin
            expSeg = 7'h7F;
            expAn  = 4'hF;
        end else begin
            expAn  = ~(4'b0001 << s);
            expSeg = hexSeg(mDisplay[4*s +: 4]);
        end
        bnd = (p == R) && (s == N - 1);
        if (bnd && mFull) begin
            mDisplay = mPending;
            mFull    = 1'b0;
        end else if (loadValid && !mFull) begin
            mPending = loadData;
            mFull    = 1'b1;
        end
        mCycle++;
        @(posedge clk);
        @(negedge clk);
        checkOutput("seg", {25'b0, seg}, {25'b0, expSeg});
        checkOutput("an", {28'b0, an}, {28'b0, expAn});
        checkOutput("ready", {31'b0, loadReady}, {31'b0, ~mFull});
    endtask

    task automatic offer(input logic [15:0] d, output logic accepted);
        logic taken;
        loadValid = 1'b1;
        loadData  = d;
        accepted  = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            taken = loadReady;
            applyStimulus();
            if (taken) begin
                accepted = 1'b1;
                break;
            end
        end
        loadValid = 1'b0;
        checkOutput("offer_accepted", {31'b0, accepted}, 32'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_seg"}, {25'b0, seg}, 32'h7F);
        checkOutput({tag, "_an"}, {28'b0, an}, 32'hF);
        checkOutput({tag, "_ready"}, {31'b0, loadReady}, 32'd1);
    endtask

    initial begin
        modelReset();
        repeat (3) begin
            @(negedge clk);
            checkReset("reset");
        end
        rst = 1'b0;

        repeat (2 * FRAME) applyStimulus();

        offer(16'h12AF, ok);
        repeat (2 * FRAME + 2) applyStimulus();

        offer(16'h0001, ok);
        offer(16'h0002, ok);
        repeat (2 * FRAME) applyStimulus();

        repeat (7) applyStimulus();
        blank = 1'b1;
        repeat (2 * FRAME) applyStimulus();
        blank = 1'b0;
        repeat (FRAME) applyStimulus();

        offer(16'h0050, ok);
        repeat (2 * FRAME) applyStimulus();
        offer(16'h0000, ok);
        repeat (2 * FRAME) applyStimulus();

        offer(16'h9C3E, ok);
        offer(16'h4D7B, ok);
        repeat (2) applyStimulus();
        #2 rst = 1'b1;
        #1 checkReset("midreset");
        modelReset();
        repeat (2) begin
            @(negedge clk);
            checkReset("midreset_hold");
        end
        rst = 1'b0;
        repeat (2 * FRAME) applyStimulus();

        for (int i = 0; i < 400; i++) begin
            if (!(loadValid && !loadReady)) begin
                loadValid = ($urandom_range(0, 3) == 0);
                loadData  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            end
            blank = ($urandom_range(0, 15) == 0);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
